// File: rtl/seq_multiplier_ctrl.sv
// ---------------------------------------------------------------------------
// seq_multiplier_ctrl
//   Sequential shift-and-add unsigned multiplier followed by an iterative
//   double-dabble binary-to-BCD converter. A single WIDTH+1 bit adder is
//   reused over WIDTH cycles, then the product is shifted into a BCD
//   register over 2*WIDTH cycles. Results are registered and handshaked.
//
//   Latency: start accepted at edge N -> done pulse after edge N+3*WIDTH.
//
// Parameters
//   WIDTH     operand width (2..4); product is 2*WIDTH bits
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     request, sampled only in IDLE or DONE
//   inp_A     multiplicand, captured on acceptance
//   inp_B     multiplier, captured on acceptance
//   busy      high while in MULT or BCD
//   done      single-cycle pulse when results are updated
//   out_ans   registered binary product
//   ans_hund  BCD hundreds digit
//   ans_ten   BCD tens digit
//   ans_unit  BCD units digit
//
// Build option
//   MULT_SKIP_ZERO_EN  when defined, a zero operand bypasses MULT/BCD and
//                      completes one cycle after acceptance with busy low.
// ---------------------------------------------------------------------------
module seq_multiplier_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   inp_A,
  input  logic [WIDTH-1:0]   inp_B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out_ans,
  output logic [3:0]         ans_hund,
  output logic [3:0]         ans_ten,
  output logic [3:0]         ans_unit
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW + 1);
  localparam logic [CW-1:0] MULT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BCD_LAST  = CW'(PW - 1);

  typedef enum logic [1:0] {IDLE, MULT, BCD, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;    // product accumulator, then BCD source shifter
  logic [PW-1:0]    prod_q;   // product held for the DONE-entry update
  logic [11:0]      bcd_q;    // {hund, ten, unit}
  logic [CW-1:0]    cnt_q;
`ifdef MULT_SKIP_ZERO_EN
  logic             skip_q;   // zero operand accepted, finish next cycle
`endif

  // Datapath next values
  logic [WIDTH:0]   sum_d;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    shl_d;
  logic [11:0]      bcd_adj;
  logic [11:0]      bcd_d;

  always_comb begin
    // Add the multiplicand into the upper half when the multiplier LSB is
    // set; the carry becomes the new MSB as the accumulator shifts right.
    sum_d = {1'b0, acc_q[PW-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d = {sum_d, acc_q[WIDTH-1:1]};

    // Double-dabble: correct nibbles >= 5 before the shift so they carry
    // properly into the next decimal digit.
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = 12'({bcd_adj, acc_q[PW-1]});
    shl_d = PW'({acc_q, 1'b0});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_ans  <= '0;
      ans_hund <= '0;
      ans_ten  <= '0;
      ans_unit <= '0;
`ifdef MULT_SKIP_ZERO_EN
      skip_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // DONE lasts exactly one cycle; default back to IDLE.
          state_q <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
`ifdef MULT_SKIP_ZERO_EN
          if (skip_q) begin
            skip_q   <= 1'b0;
            state_q  <= DONE;
            done     <= 1'b1;
            out_ans  <= '0;
            ans_hund <= '0;
            ans_ten  <= '0;
            ans_unit <= '0;
          end else if (start && (inp_A == '0 || inp_B == '0)) begin
            skip_q <= 1'b1;
          end else
`endif
          if (start) begin
            state_q  <= MULT;
            busy     <= 1'b1;
            mcand_q  <= inp_A;
            mplier_q <= inp_B;
            acc_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
          end
        end

        MULT: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == MULT_LAST) begin
            state_q <= BCD;
            prod_q  <= acc_d;
            cnt_q   <= '0;
          end
        end

        BCD: begin
          bcd_q <= bcd_d;
          acc_q <= shl_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == BCD_LAST) begin
            state_q  <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cnt_q    <= '0;
            out_ans  <= prod_q;
            ans_hund <= bcd_d[11:8];
            ans_ten  <= bcd_d[7:4];
            ans_unit <= bcd_d[3:0];
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
module tb_seq_multiplier_ctrl;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   inp_A = '0;
  logic [W-1:0]   inp_B = '0;
  logic           busy, done;
  logic [2*W-1:0] out_ans;
  logic [3:0]     ans_hund, ans_ten, ans_unit;

  int n_checks = 0;
  int n_fail   = 0;

  seq_multiplier_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .inp_A(inp_A), .inp_B(inp_B),
    .busy(busy), .done(done), .out_ans(out_ans),
    .ans_hund(ans_hund), .ans_ten(ans_ten), .ans_unit(ans_unit)
  );

  always #5 clk = ~clk;

  // Stimulus: present operands with start for one edge; returns at the
  // negedge following the accepting edge.
  task automatic launch(input int a, input int b);
    @(negedge clk);
    inp_A = W'(a); inp_B = W'(b); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Stimulus: step until done is seen (bounded), reporting edges elapsed
  // and how many samples had busy high.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_checks++; if ({out_ans, ans_hund, ans_ten, ans_unit} !== '0) begin n_fail++; $display("FAIL reset_outs: got ans=%0d h=%0d t=%0d u=%0d want 0", out_ans, ans_hund, ans_ten, ans_unit); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_ans !== '0) begin
        n_fail++; $display("FAIL idle_quiet: cyc %0d busy=%0b done=%0b ans=%0d want 0/0/0", i, busy, done, out_ans);
      end
    end
  endtask

  task automatic test_mult_7x7;
    int lat, bcnt;
    launch(7, 7);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL 7x7_busy_rise: got %0b want 1", busy); end
    wait_done(lat, bcnt);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL 7x7_latency: got %0d want 9", lat); end
    n_checks++; if (bcnt !== 9) begin n_fail++; $display("FAIL 7x7_busy_cycles: got %0d want 9", bcnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL 7x7_busy_at_done: got %0b want 0", busy); end
    n_checks++; if (out_ans !== 6'd49) begin n_fail++; $display("FAIL 7x7_ans: got %0d want 49", out_ans); end
    n_checks++; if (ans_hund !== 4'd0) begin n_fail++; $display("FAIL 7x7_hund: got %0d want 0", ans_hund); end
    n_checks++; if (ans_ten !== 4'd4) begin n_fail++; $display("FAIL 7x7_ten: got %0d want 4", ans_ten); end
    n_checks++; if (ans_unit !== 4'd9) begin n_fail++; $display("FAIL 7x7_unit: got %0d want 9", ans_unit); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL 7x7_done_pulse: got %0b want 0", done); end
    n_checks++; if (out_ans !== 6'd49) begin n_fail++; $display("FAIL 7x7_hold: got %0d want 49", out_ans); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    launch(5, 3);
    wait_done(lat, bcnt);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL b2b_lat1: got %0d want 9", lat); end
    n_checks++; if (out_ans !== 6'd15) begin n_fail++; $display("FAIL b2b_ans1: got %0d want 15", out_ans); end
    n_checks++; if (ans_ten !== 4'd1 || ans_unit !== 4'd5) begin n_fail++; $display("FAIL b2b_digits1: got %0d%0d want 15", ans_ten, ans_unit); end
    // start high while in DONE
    inp_A = 3'd6; inp_B = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; inp_A = 3'd0; inp_B = 3'd0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %0b want 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_pulse: got %0b want 0", done); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_ans !== 6'd15 || ans_ten !== 4'd1 || ans_unit !== 4'd5) begin
        n_fail++; $display("FAIL b2b_hold: cyc %0d got ans=%0d t=%0d u=%0d want 15/1/5", i, out_ans, ans_ten, ans_unit);
      end
      @(negedge clk);
    end
    wait_done(lat, bcnt);
    n_checks++; if (lat + 5 + 1 !== 10) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 10", lat + 6); end
    n_checks++; if (out_ans !== 6'd24) begin n_fail++; $display("FAIL b2b_ans2: got %0d want 24", out_ans); end
    n_checks++; if (ans_ten !== 4'd2 || ans_unit !== 4'd4) begin n_fail++; $display("FAIL b2b_digits2: got %0d%0d want 24", ans_ten, ans_unit); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat, bcnt;
    launch(6, 7);
    @(negedge clk);
    inp_A = 3'd1; inp_B = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL ign_lat: got %0d want 7", lat); end
    n_checks++; if (out_ans !== 6'd42) begin n_fail++; $display("FAIL ign_ans: got %0d want 42", out_ans); end
    n_checks++; if (ans_ten !== 4'd4 || ans_unit !== 4'd2) begin n_fail++; $display("FAIL ign_digits: got %0d%0d want 42", ans_ten, ans_unit); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ign_requeue: busy=%0b done=%0b want 0/0", busy, done); end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, dcnt;
    launch(7, 6);
    for (int i = 0; i < 5; i++) @(negedge clk);  // now in BCD phase
    rst = 1'b1;
    #1;
    n_checks++; if (out_ans !== '0 || {ans_hund, ans_ten, ans_unit} !== '0) begin n_fail++; $display("FAIL rstmid_outs: got ans=%0d digits=%0h want 0", out_ans, {ans_hund, ans_ten, ans_unit}); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: busy=%0b done=%0b want 0/0", busy, done); end
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    n_checks++; if (dcnt !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", dcnt); end
    launch(2, 3);
    wait_done(lat, bcnt);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL rstmid_lat: got %0d want 9", lat); end
    n_checks++; if (out_ans !== 6'd6) begin n_fail++; $display("FAIL rstmid_ans: got %0d want 6", out_ans); end
    n_checks++; if (ans_ten !== 4'd0 || ans_unit !== 4'd6) begin n_fail++; $display("FAIL rstmid_digits: got %0d%0d want 06", ans_ten, ans_unit); end
    @(negedge clk);
  endtask

  task automatic test_zero;
    int lat, bcnt;
    int exp_lat, exp_bcnt;
`ifdef MULT_SKIP_ZERO_EN
    exp_lat = 1; exp_bcnt = 0;
`else
    exp_lat = 9; exp_bcnt = 9;
`endif
    launch(0, 5);
    wait_done(lat, bcnt);
    n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL zero_lat: got %0d want %0d", lat, exp_lat); end
    n_checks++; if (bcnt !== exp_bcnt) begin n_fail++; $display("FAIL zero_busy: got %0d want %0d", bcnt, exp_bcnt); end
    n_checks++; if (out_ans !== '0 || {ans_hund, ans_ten, ans_unit} !== '0) begin n_fail++; $display("FAIL zero_outs: got ans=%0d digits=%0h want 0", out_ans, {ans_hund, ans_ten, ans_unit}); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %0b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_mult_7x7();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_ctrl.md
# seq_multiplier_ctrl

Sequential shift-and-add unsigned multiplier controller with start/busy/done handshake and an iterative binary-to-BCD stage producing decimal digits for the seven-segment display path. It time-multiplexes a single adder over WIDTH cycles instead of using an array of adders, then converts the product with a double-dabble sequencer. It sits between the switch/button input logic and the display driver, replacing the combinational multiplier for designs that need registered, handshaked results.

## Interface
- WIDTH, 3, operand width in bits; legal range 2..4; product is 2*WIDTH bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- inp_A  input  WIDTH  multiplicand, captured when start is accepted
- inp_B  input  WIDTH  multiplier, captured when start is accepted
- busy  output  1  high in MULT and BCD states
- done  output  1  one-cycle pulse in DONE state; results valid
- out_ans  output  2*WIDTH  registered binary product
- ans_hund  output  4  BCD hundreds digit (always 0 for WIDTH ≤ 3)
- ans_ten  output  4  BCD tens digit
- ans_unit  output  4  BCD units digit

## Operation
- States: IDLE, MULT, BCD, DONE.
- IDLE: start=1 → latch inp_A into multiplicand reg, inp_B into multiplier shift reg, clear accumulator and counter, go MULT.
- MULT: each cycle, if multiplier LSB=1, add multiplicand to upper half of accumulator; shift accumulator and multiplier right by 1. After exactly WIDTH cycles go BCD. Counter width is sized for 2*WIDTH.
- BCD: double-dabble over 2*WIDTH cycles: before each shift, any BCD nibble ≥5 gets +3; shift product MSB into BCD register. After 2*WIDTH cycles go DONE.
- DONE: out_ans, ans_hund, ans_ten, ans_unit update on entry and hold until next DONE entry. done=1 for this single cycle. Next edge: start=1 → MULT (new operands latched); else IDLE.
- start in MULT or BCD is ignored (not queued).
- Outputs are registers; internal intermediate values never appear on output ports.
- Arithmetic unsigned; product max (2^WIDTH−1)^2 fits 2*WIDTH bits, no overflow.

## Timing
- Reset (async, any state): state=IDLE, busy=0, done=0, out_ans=0, all digits=0, internal regs=0. Reset mid-operation aborts the operation; no done is produced.
- start sampled high at edge N in IDLE → busy=1 after edge N.
- busy falls and done rises after edge N+3*WIDTH (9 cycles for WIDTH=3); done falls after edge N+3*WIDTH+1.
- Back-to-back: start high during DONE → done stays a one-cycle pulse, busy=1 next cycle; throughput one result per 3*WIDTH+1 cycles.
- inp_A/inp_B may change freely while busy; only values at acceptance matter.

## Configuration
- MULT_SKIP_ZERO_EN defined: on acceptance, if inp_A==0 or inp_B==0, go directly to DONE with out_ans=0 and all digits 0; done rises after edge N+1, busy never asserts.
- Not defined: zero operands take the full 3*WIDTH-cycle path, producing zero results.

## Test plan
- Reset then idle: all outputs 0, busy=0, done=0 indefinitely with start=0.
- inp_A=7, inp_B=7, start one cycle → busy 9 cycles, done pulse; out_ans=49, ans_ten=4, ans_unit=9, ans_hund=0.
- inp_A=5, inp_B=3 → out_ans=15, ans_ten=1, ans_unit=5; then start held high through DONE with inp_A=6, inp_B=4 → second done 10 cycles after the first, out_ans=24, ans_ten=2, ans_unit=4; first results held until then.
- start pulsed again and inputs changed (inp_A=1, inp_B=1) mid-MULT of 6×7 → ignored; result out_ans=42, ans_ten=4, ans_unit=2.
- rst asserted during BCD of 7×6 → outputs 0 immediately, no done; subsequent 2×3 gives out_ans=6.
- inp_A=0, inp_B=5: with MULT_SKIP_ZERO_EN done after 1 cycle, busy never high; without, done after 9 cycles; out_ans=0 both cases.
